qk_sched: RTL and testbench

- Round-robin scheduler that shares one QK score engine among NREQ requesters (attention heads / query producers).
- Grants one requester at a time and sequences a burst of query rows through the engine: one start pulse per row, waiting for the engine's done before issuing the next row.
- Steers operand muxes through grant_idx/q_idx and acknowledges the requester when its burst completes.

---
 rtl/qk_sched_if.sv | 31 +++
 rtl/qk_sched.sv | 148 ++++++++++++++
 tb/tb_qk_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qk_sched_if.sv
// Request/grant and score-engine handshake bundle for qk_sched.
// master = scheduler side, slave = requesters plus engine.
interface qk_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned MAX_Q = 8,
    parameter int unsigned QW    = $clog2(MAX_Q) + 1
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*QW-1:0] req_nq;
    logic [NREQ-1:0]    grant;
    logic [IW-1:0]      grant_idx;
    logic [QW-1:0]      q_idx;
    logic               eng_start;
    logic               eng_done;
    logic               row_done;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic               err;

    modport master (
        input  req, req_nq, eng_done,
        output grant, grant_idx, q_idx, eng_start, row_done, ack, busy, err
    );

    modport slave (
        output req, req_nq, eng_done,
        input  grant, grant_idx, q_idx, eng_start, row_done, ack, busy, err
    );
endinterface

// File: rtl/qk_sched.sv
// Round-robin scheduler sharing one QK score engine across NREQ requesters, row by row.
// Optional WAIT watchdog enabled by defining QK_SCHED_WDOG_EN.
module qk_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MAX_Q       = 8,
    parameter int unsigned QW          = $clog2(MAX_Q) + 1,
    parameter int unsigned WDOG_CYCLES = 256
) (
    input logic        clk,
    input logic        rst_n,
    qk_sched_if.master bus
);
    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2) begin : g_bad_nreq
        $error("qk_sched: NREQ must be at least 2");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("qk_sched: WDOG_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e          state_q;
    logic [NREQ-1:0] grant_q, ack_q;
    logic [IW-1:0]   grant_idx_q, last_q;
    logic [QW-1:0]   q_idx_q, nq_q;
    logic            eng_start_q, row_done_q, busy_q;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [QW-1:0]   raw_nq, pick_nq;

    // First pending requester after the last one served, wrapping.
    always_comb begin
        int unsigned cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!pick_vld && bus.req[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
        raw_nq  = bus.req_nq[pick_idx*QW +: QW];
        pick_nq = (raw_nq > QW'(MAX_Q)) ? QW'(MAX_Q) : raw_nq;
    end

`ifdef QK_SCHED_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q;
    logic          err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= IW'(NREQ - 1);
            q_idx_q     <= '0;
            nq_q        <= '0;
            eng_start_q <= 1'b0;
            row_done_q  <= 1'b0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
`ifdef QK_SCHED_WDOG_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
            row_done_q  <= 1'b0;
            ack_q       <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        grant_q     <= NREQ'(1) << pick_idx;
                        grant_idx_q <= pick_idx;
                        nq_q        <= pick_nq;
                        q_idx_q     <= '0;
                        busy_q      <= 1'b1;
                        // Empty burst skips the engine entirely.
                        if (pick_nq == '0) begin
                            ack_q   <= NREQ'(1) << pick_idx;
                            state_q <= StAck;
                        end else begin
                            eng_start_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
`ifdef QK_SCHED_WDOG_EN
                    wdog_q  <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    // row_done_q marks the turnaround cycle after eng_done.
                    if (row_done_q) begin
                        if (q_idx_q < nq_q - 1'b1) begin
                            q_idx_q     <= q_idx_q + 1'b1;
                            eng_start_q <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            ack_q   <= grant_q;
                            state_q <= StAck;
                        end
                    end else if (bus.eng_done) begin
                        row_done_q <= 1'b1;
`ifdef QK_SCHED_WDOG_EN
                    end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        ack_q   <= grant_q;
                        state_q <= StAck;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
`endif
                    end
                end
                StAck: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= grant_idx_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.q_idx     = q_idx_q;
    assign bus.eng_start = eng_start_q;
    assign bus.row_done  = row_done_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
`ifdef QK_SCHED_WDOG_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_qk_sched.sv
// Scoreboard bench for qk_sched: a round-robin order model predicts row/ack events,
// a monitor compares them as the DUT emits row_done, eng_start and ack.
module tb_qk_sched;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned MAX_Q = 8;
    localparam int unsigned QW    = $clog2(MAX_Q) + 1;
    localparam int unsigned IW    = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qk_sched_if #(.NREQ(NREQ), .MAX_Q(MAX_Q), .QW(QW)) bus ();

    qk_sched #(.NREQ(NREQ), .MAX_Q(MAX_Q), .QW(QW), .WDOG_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [NREQ-1:0] req;
    logic [QW-1:0]   nq [NREQ];
    logic            done_eng, done_stray;

    assign bus.req      = req;
    assign bus.eng_done = done_eng | done_stray;
    for (genvar g = 0; g < NREQ; g++) begin : g_nq
        assign bus.req_nq[g*QW +: QW] = nq[g];
    end

    typedef struct {bit is_ack; int idx; int q;} ev_t;
    ev_t exp_q[$];
    int  start_t[$];
    int  total = 0;
    int  bad = 0;
    int  model_last = NREQ - 1;
    int  eng_lat = 0;
    bit  eng_hang = 1'b0;
    bit  wdog_mode = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic [31:0] out_vec();
        return 32'({bus.grant, bus.grant_idx, bus.q_idx, bus.eng_start, bus.row_done, bus.ack,
                    bus.busy, bus.err});
    endfunction

    function automatic logic [31:0] ev_code(ev_t e);
        return e.is_ack ? (32'h100 | (32'd1 << e.idx)) : 32'(e.idx * 16 + e.q);
    endfunction

    // Reference: serve pending requesters in round-robin order from model_last.
    task automatic plan(input logic [NREQ-1:0] mask, input int n_serv, input bit hold,
                        input bit no_rows);
        logic [NREQ-1:0] pend;
        int last, pick, c, rows;
        pend = mask;
        last = model_last;
        for (int k = 0; k < n_serv; k++) begin
            pick = -1;
            for (int s = 1; s <= NREQ; s++) begin
                c = (last + s) % NREQ;
                if (pick < 0 && pend[c]) pick = c;
            end
            if (pick < 0) break;
            rows = (int'(nq[pick]) > MAX_Q) ? MAX_Q : int'(nq[pick]);
            if (!no_rows)
                for (int r = 0; r < rows; r++) exp_q.push_back('{1'b0, pick, r});
            exp_q.push_back('{1'b1, pick, 0});
            if (!hold) pend[pick] = 1'b0;
            last = pick;
        end
        model_last = last;
    endtask

    task automatic run_round(input logic [NREQ-1:0] mask, input int n_serv, input bit hold,
                             input int drop, input bit stray, input bit no_rows);
        int served, it;
        served = 0;
        it = 0;
        plan(mask, n_serv, hold, no_rows);
        start_t.delete();
        @(negedge clk);
        req = mask;
        while (served < n_serv && it < 3000) begin
            @(negedge clk);
            it++;
            done_stray = 1'b0;
            if (bus.eng_start) begin
                start_t.push_back(it);
                if (stray) done_stray = 1'b1;
                if (drop >= 0) req[drop] = 1'b0;
            end
            if (|bus.ack) begin
                served++;
                if (!hold) req = req & ~bus.ack;
                if (served == n_serv) req = '0;
            end
        end
        done_stray = 1'b0;
        if (served < n_serv) begin
            chk("round_timeout", 32'(served), 32'(n_serv));
            exp_q.delete();
            req = '0;
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every DUT event against the head of the expected queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
                if (bus.eng_start && !wdog_mode) begin
                    if (exp_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
                    else chk("start_row", 32'(bus.grant_idx * 16 + bus.q_idx), ev_code(exp_q[0]));
                end
                if (bus.row_done) begin
                    if (exp_q.size() == 0) chk("row_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("row_done", 32'(bus.grant_idx * 16 + bus.q_idx), ev_code(e));
                        chk("row_grant", 32'(bus.grant), 32'd1 << bus.grant_idx);
                    end
                end
                if (|bus.ack) begin
                    if (exp_q.size() == 0) chk("ack_unexpected", 32'(bus.ack), 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("ack", 32'h100 | 32'(bus.ack), ev_code(e));
                        chk("ack_grant", 32'(bus.grant), 32'(bus.ack));
                    end
                end
            end
        end
    end

    // Score engine model: done pulse eng_lat cycles after start (random when 0).
    initial begin
        int l;
        done_eng = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_start && !eng_hang) begin
                l = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 5));
                repeat (l) @(negedge clk);
                done_eng = 1'b1;
                @(negedge clk);
                done_eng = 1'b0;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [NREQ-1:0] m;
        req = '0;
        done_stray = 1'b0;
        for (int i = 0; i < NREQ; i++) nq[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", out_vec(), 32'd0);

        // Single 3-row burst, fixed engine latency 5.
        eng_lat = 5;
        nq[0] = 3;
        run_round(4'b0001, 1, 1'b0, -1, 1'b0, 1'b0);
        chk("t1_starts", 32'(start_t.size()), 32'd3);
        if (start_t.size() == 3) begin
            chk("t1_first_start", 32'(start_t[0]), 32'd1);
            chk("t1_row_period0", 32'(start_t[1] - start_t[0]), 32'd7);
            chk("t1_row_period1", 32'(start_t[2] - start_t[1]), 32'd7);
        end

        // All requesters held, one row each: five grants in rotation.
        eng_lat = 0;
        for (int i = 0; i < NREQ; i++) nq[i] = 1;
        run_round(4'b1111, 5, 1'b1, -1, 1'b0, 1'b0);

        // Empty burst goes straight to ack.
        nq[2] = 0;
        run_round(4'b0100, 1, 1'b0, -1, 1'b0, 1'b0);
        chk("t3_no_start", 32'(start_t.size()), 32'd0);

        // Async reset in WAIT of a 4-row burst.
        eng_lat = 5;
        nq[0] = 4;
        plan(4'b0001, 1, 1'b0, 1'b0);
        @(negedge clk);
        req = 4'b0001;
        cnt = 0;
        for (int it = 0; it < 200 && cnt < 2; it++) begin
            @(negedge clk);
            if (bus.eng_start) cnt++;
        end
        chk("t4_reached_row1", 32'(cnt), 32'd2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t4_async_reset", out_vec(), 32'd0);
        exp_q.delete();
        req = '0;
        model_last = NREQ - 1;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        eng_lat = 0;
        nq[1] = 2;
        nq[3] = 1;
        run_round(4'b1010, 2, 1'b0, -1, 1'b0, 1'b0);

        // Stray eng_done in IDLE and ISSUE; req1 dropped after its first start.
        @(negedge clk);
        done_stray = 1'b1;
        @(negedge clk);
        done_stray = 1'b0;
        chk("t5_idle_stray", 32'({bus.busy, bus.row_done, bus.eng_start}), 32'd0);
        nq[1] = 3;
        run_round(4'b0010, 1, 1'b0, 1, 1'b1, 1'b0);
        chk("t5_starts", 32'(start_t.size()), 32'd3);

        // Random rounds.
        for (int r = 0; r < 20; r++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) nq[i] = QW'($urandom_range(0, 10));
            run_round(m, $countones(m), 1'b0, -1, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef QK_SCHED_WDOG_EN
        // Engine never answers: watchdog aborts, acks, then the next requester runs.
        eng_hang = 1'b1;
        wdog_mode = 1'b1;
        nq[0] = 2;
        run_round(4'b0001, 1, 1'b0, -1, 1'b0, 1'b1);
        chk("wdog_err", 32'(bus.err), 32'd1);
        eng_hang = 1'b0;
        wdog_mode = 1'b0;
        nq[1] = 1;
        run_round(4'b0010, 1, 1'b0, -1, 1'b0, 1'b0);
`else
        chk("err_tied", 32'(bus.err), 32'd0);
`endif

        chk("sb_final", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
